// File: rtl/alu_pkg.sv
// Shared types and constants for the alu_pipe execute stage.
// The iterative multiplier is only built when ALU_MUL_EN is defined.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_XOR    = 4'd2,
    ALU_RED    = 4'd3,
    ALU_SLL    = 4'd4,
    ALU_SRA    = 4'd5,
    ALU_ROR    = 4'd6,
    ALU_PADDSB = 4'd7,
    ALU_AND    = 4'd8,
    ALU_OR     = 4'd9,
    ALU_MUL    = 4'd10
  } alu_op_e;

  localparam int FLAG_Z = 0;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 2;

  typedef enum logic {
    IDLE     = 1'b0,
    MUL_BUSY = 1'b1
  } alu_state_e;

  localparam int PADDSB_LANE = 4;

endpackage

// File: rtl/alu_mul_iter.sv
// Shift-add multiplier: the start cycle performs the first iteration, then one
// iteration per cycle; done_o/prod_o flag the final iteration combinationally.
module alu_mul_iter #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] prod_o
);

  localparam int CNT_W = $clog2(WIDTH);

  logic [WIDTH-1:0] acc_q, mcand_q, mplier_q, stepSum;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;

  assign stepSum = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign done_o  = busy_q && (cnt_q == CNT_W'(WIDTH - 1));
  assign prod_o  = stepSum;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else if (start_i) begin
      acc_q    <= b_i[0] ? a_i : '0;
      mcand_q  <= a_i << 1;
      mplier_q <= b_i >> 1;
      cnt_q    <= CNT_W'(1);
      busy_q   <= 1'b1;
    end else if (busy_q) begin
      acc_q    <= stepSum;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + 1'b1;
      if (done_o) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Handshaked WIDTH-generic execute-stage ALU with registered result and NVZ flags.
// Define ALU_MUL_EN to build the iterative multiplier for opcode 10.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] rd,
  output logic [2:0]       flag
);

  localparam int SHAMT_W = $clog2(WIDTH);
  localparam int NBYTES  = WIDTH / 8;
  localparam int NLANES  = WIDTH / PADDSB_LANE;

  logic [WIDTH-1:0]     rd_q, res_d, redSum, paddSum;
  logic [2:0]           flag_q;
  logic                 out_valid_q, accept, loadAlu, wrNV, wrZ, satV;
  logic [WIDTH:0]       sumExt;
  logic [PADDSB_LANE:0] laneSum;
  logic [SHAMT_W-1:0]   shamt;

  assign accept    = in_valid && in_ready;
  assign shamt     = rt[SHAMT_W-1:0];
  assign rd        = rd_q;
  assign flag      = flag_q;
  assign out_valid = out_valid_q;

`ifdef ALU_MUL_EN
  alu_state_e       state_q;
  logic             mulStart, mulDone;
  logic [WIDTH-1:0] mulProd;

  assign in_ready = (state_q == IDLE) && (!out_valid_q || out_ready);
  assign mulStart = accept && (opcode == ALU_MUL);
  assign loadAlu  = accept && (opcode != ALU_MUL);

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk_i  (clk),
    .rst_ni (rst),
    .start_i(mulStart),
    .a_i    (rs),
    .b_i    (rt),
    .done_o (mulDone),
    .prod_o (mulProd)
  );
`else
  assign in_ready = !out_valid_q || out_ready;
  assign loadAlu  = accept;
`endif

  always_comb begin
    redSum = '0;
    for (int i = 0; i < NBYTES; i++) begin
      redSum = redSum + {{(WIDTH-8){rs[8*i+7]}}, rs[8*i +: 8]}
                      + {{(WIDTH-8){rt[8*i+7]}}, rt[8*i +: 8]};
    end
  end

  // Each lane adds with one guard bit; a guard/sign disagreement means the lane overflowed.
  always_comb begin
    paddSum = '0;
    laneSum = '0;
    for (int l = 0; l < NLANES; l++) begin
      laneSum = {rs[PADDSB_LANE*l+PADDSB_LANE-1], rs[PADDSB_LANE*l +: PADDSB_LANE]}
              + {rt[PADDSB_LANE*l+PADDSB_LANE-1], rt[PADDSB_LANE*l +: PADDSB_LANE]};
      if (laneSum[PADDSB_LANE] != laneSum[PADDSB_LANE-1])
        paddSum[PADDSB_LANE*l +: PADDSB_LANE] = laneSum[PADDSB_LANE] ?
          {1'b1, {(PADDSB_LANE-1){1'b0}}} : {1'b0, {(PADDSB_LANE-1){1'b1}}};
      else
        paddSum[PADDSB_LANE*l +: PADDSB_LANE] = laneSum[PADDSB_LANE-1:0];
    end
  end

  always_comb begin
    res_d  = '0;
    sumExt = '0;
    satV   = 1'b0;
    wrNV   = 1'b0;
    wrZ    = 1'b0;
    case (opcode)
      ALU_ADD, ALU_SUB: begin
        sumExt = (opcode == ALU_ADD) ? {rs[WIDTH-1], rs} + {rt[WIDTH-1], rt}
                                     : {rs[WIDTH-1], rs} - {rt[WIDTH-1], rt};
        satV   = sumExt[WIDTH] ^ sumExt[WIDTH-1];
        res_d  = satV ? (sumExt[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}})
                      : sumExt[WIDTH-1:0];
        wrNV   = 1'b1;
        wrZ    = 1'b1;
      end
      ALU_XOR:    begin res_d = rs ^ rt;                      wrZ = 1'b1; end
      ALU_RED:    res_d = redSum;
      ALU_SLL:    begin res_d = rs << shamt;                  wrZ = 1'b1; end
      ALU_SRA:    begin res_d = $signed(rs) >>> shamt;        wrZ = 1'b1; end
      ALU_ROR:    begin res_d = WIDTH'({rs, rs} >> shamt);    wrZ = 1'b1; end
      ALU_PADDSB: res_d = paddSum;
      ALU_AND:    begin res_d = rs & rt;                      wrZ = 1'b1; end
      ALU_OR:     begin res_d = rs | rt;                      wrZ = 1'b1; end
      default:    res_d = '0;
    endcase
  end

  // Flags are written together with rd; a drain alone never touches them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_q        <= '0;
      out_valid_q <= 1'b0;
      flag_q      <= 3'b000;
`ifdef ALU_MUL_EN
      state_q     <= IDLE;
`endif
    end else begin
      if (out_valid_q && out_ready) out_valid_q <= 1'b0;
      if (loadAlu) begin
        rd_q        <= res_d;
        out_valid_q <= 1'b1;
        if (wrZ) flag_q[FLAG_Z] <= (res_d == '0);
        if (wrNV) begin
          flag_q[FLAG_N] <= res_d[WIDTH-1];
          flag_q[FLAG_V] <= satV;
        end
      end
`ifdef ALU_MUL_EN
      case (state_q)
        IDLE:     if (mulStart) state_q <= MUL_BUSY;
        MUL_BUSY: if (mulDone) begin
          rd_q           <= mulProd;
          out_valid_q    <= 1'b1;
          flag_q[FLAG_Z] <= (mulProd == '0);
          state_q        <= IDLE;
        end
        default:  state_q <= IDLE;
      endcase
`endif
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: an input monitor pushes reference-model results,
// an output monitor pops and compares them. Honours ALU_MUL_EN like the RTL.
module tb_alu_pipe;

  localparam int W  = 16;
  localparam int SW = $clog2(W);
`ifdef ALU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic         clk = 1'b0, rst = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic         in_ready, out_valid;
  logic [3:0]   opcode = 4'd0;
  logic [W-1:0] rs = '0, rt = '0, rd;
  logic [2:0]   flag;

  alu_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .rs(rs), .rt(rt), .out_valid(out_valid),
    .out_ready(out_ready), .rd(rd), .flag(flag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] rd;
    logic [2:0]   flag;
    int           lat;
    int           acceptCyc;
    bit           seen;
  } exp_t;

  exp_t         sbQ[$];
  int           checks = 0, fails = 0, cyc = 0;
  logic [2:0]   modelFlag = 3'b000;
  bit           mulPending = 1'b0, randReady = 1'b0;
  logic [W-1:0] edgeVals[6] = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF, 16'h00FF};

  always @(posedge clk) cyc++;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: plain integer arithmetic on the architectural rules.
  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    longint r, sa, sb, maxS, minS;
    int n, s;
    bit v;
    logic [W-1:0] x;
    logic [7:0] by;
    logic [3:0] na, nb;
    logic [SW-1:0] amt;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    maxS = (longint'(1) <<< (W-1)) - 1;
    minS = -(longint'(1) <<< (W-1));
    amt = b[SW-1:0];
    n = int'(amt);
    e.flag = modelFlag; e.lat = 1; e.acceptCyc = cyc; e.seen = 1'b0; e.rd = '0;
    case (op)
      4'd0, 4'd1: begin
        r = (op == 4'd0) ? sa + sb : sa - sb;
        v = (r > maxS) || (r < minS);
        if (r > maxS) r = maxS;
        if (r < minS) r = minS;
        e.rd = r[W-1:0];
        e.flag = {e.rd[W-1], v, e.rd == '0};
      end
      4'd2: e.rd = a ^ b;
      4'd3: begin
        r = 0;
        for (int i = 0; i < W/8; i++) begin
          by = a[8*i +: 8]; r += longint'($signed(by));
          by = b[8*i +: 8]; r += longint'($signed(by));
        end
        e.rd = r[W-1:0];
      end
      4'd4: e.rd = a << n;
      4'd5: begin r = sa >>> n; e.rd = r[W-1:0]; end
      4'd6: begin
        x = a;
        for (int k = 0; k < n; k++) x = {x[0], x[W-1:1]};
        e.rd = x;
      end
      4'd7: begin
        for (int l = 0; l < W/4; l++) begin
          na = a[4*l +: 4]; nb = b[4*l +: 4];
          s = int'($signed(na)) + int'($signed(nb));
          if (s > 7) s = 7;
          if (s < -8) s = -8;
          e.rd[4*l +: 4] = s[3:0];
        end
      end
      4'd8: e.rd = a & b;
      4'd9: e.rd = a | b;
      4'd10: if (MUL_EN) begin
        r = longint'(a) * longint'(b);
        e.rd = r[W-1:0];
        e.lat = W;
      end
      default: e.rd = '0;
    endcase
    if (op inside {4'd2, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9} || (op == 4'd10 && MUL_EN))
      e.flag[0] = (e.rd == '0);
    return e;
  endfunction

  // Output side first (pop/compare), then in_ready rule, then input side (push).
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      if (out_valid) begin
        if (sbQ.size() == 0) begin
          checks++; fails++;
          $display("[TB] FAIL spurious_result: got rd=0x%0h with no outstanding op", rd);
        end else begin
          if (!sbQ[0].seen) begin
            sbQ[0].seen = 1'b1;
            mulPending = 1'b0;
            checkOutput("latency", cyc - sbQ[0].acceptCyc, sbQ[0].lat);
          end
          checkOutput("rd", rd, sbQ[0].rd);
          checkOutput("flag", flag, sbQ[0].flag);
          if (out_ready) void'(sbQ.pop_front());
        end
      end
      checkOutput("in_ready", in_ready, !mulPending && (!out_valid || out_ready));
      if (in_valid && in_ready) begin
        e = model(opcode, rs, rt);
        modelFlag = e.flag;
        sbQ.push_back(e);
        if (MUL_EN && opcode == 4'd10) mulPending = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (randReady) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic applyStimulus(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bit acc = 1'b0;
    in_valid = 1'b1; opcode = op; rs = a; rt = b;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      tick();
    end
    in_valid = 1'b0;
    if (!acc) begin
      checks++; fails++;
      $display("[TB] FAIL accept_timeout: op %0d never accepted", op);
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((sbQ.size() != 0 || out_valid) && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) begin
      checks++; fails++;
      $display("[TB] FAIL drain_timeout: %0d results still outstanding", sbQ.size());
    end
  endtask

  task automatic doReset();
    rst = 1'b0;
    sbQ.delete();
    modelFlag = 3'b000;
    mulPending = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [W-1:0] a, b;
    doReset();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_out_valid", out_valid, 1'b0);
    checkOutput("reset_rd", rd, 16'h0000);
    checkOutput("reset_flag", flag, 3'b000);
    rst = 1'b1;
    tick(); tick();

    // Reset in the middle of a multiply: flags clear and nothing is ever emitted.
    applyStimulus(4'd0, 16'h7FFF, 16'h0001);
    applyStimulus(4'd10, 16'h0003, 16'h0004);
    tick(); tick();
    doReset();
    #1;
    checkOutput("midmul_out_valid", out_valid, 1'b0);
    checkOutput("midmul_flag", flag, 3'b000);
    tick();
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midmul_in_ready", in_ready, 1'b1);
    repeat (20) tick();

    applyStimulus(4'd0, 16'h7FFF, 16'h0001);
    applyStimulus(4'd1, 16'h8000, 16'h0001);
    applyStimulus(4'd1, 16'h0005, 16'h0005);
    applyStimulus(4'd2, 16'h00FF, 16'h0F0F);
    applyStimulus(4'd10, 16'h0012, 16'h0034);
    drain();

    // Backpressure: second op stalls until the held result drains.
    out_ready = 1'b0;
    applyStimulus(4'd0, 16'h0001, 16'h0002);
    in_valid = 1'b1; opcode = 4'd0; rs = 16'h0003; rt = 16'h0004;
    repeat (4) begin
      @(negedge clk);
      checkOutput("bp_hold_rd", rd, 16'h0003);
      checkOutput("bp_in_ready", in_ready, 1'b0);
      tick();
    end
    out_ready = 1'b1;
    applyStimulus(4'd0, 16'h0003, 16'h0004);
    @(negedge clk);
    checkOutput("bp_second_rd", rd, 16'h0007);
    tick();

    applyStimulus(4'd7, 16'h7777, 16'h1111);
    applyStimulus(4'd6, 16'h8001, 16'h0004);
    applyStimulus(4'd5, 16'h8000, 16'h000F);
    applyStimulus(4'd3, 16'h7F7F, 16'h0102);
    applyStimulus(4'd4, 16'h1234, 16'h0000);
    applyStimulus(4'd12, 16'h1234, 16'h5678);
    drain();

    randReady = 1'b1;
    for (int i = 0; i < 300; i++) begin
      a = ($urandom_range(0, 3) == 0) ? edgeVals[$urandom_range(0, 5)] : W'($urandom);
      b = ($urandom_range(0, 3) == 0) ? edgeVals[$urandom_range(0, 5)] : W'($urandom);
      applyStimulus(4'($urandom_range(0, 15)), a, b);
      if ($urandom_range(0, 4) == 0) tick();
    end
    randReady = 1'b0;
    out_ready = 1'b1;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
